// File: rtl/serial_adder_nbit.sv
// Bit-serial adder/subtractor: latches two WIDTH-bit operands on START and
// resolves one bit per clock through a single full-adder cell and carry flop.
module serial_adder_nbit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             START,
  input  logic             SUB,
  input  logic             CIN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_s;
  logic             bit_c;

  // Single full-adder cell on the low operand bits and the carry flop
  always_comb begin
    bit_s = a_q[0] ^ b_q[0] ^ c_q;
    bit_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (START) begin
          a_d     = A;
          b_d     = SUB ? ~B : B;
          c_d     = SUB ? 1'b1 : CIN;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        busy_d = 1'b1;
        c_d    = bit_c;
        acc_d  = (acc_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = bit_c;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SUM  = sum_q;
  assign COUT = cout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit: WIDTH=8 and WIDTH=1 instances checked against
// plain-arithmetic expectations, including timing, ignored STARTs and reset.
module tb_serial_adder_nbit;

  logic       clk;
  logic       rst;
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, busy8, done8;
  logic       start1, sub1, cin1;
  logic [0:0] a1, b1, sum1;
  logic       cout1, busy1, done1;

  int total;
  int bad;
  logic [7:0] old_sum8;
  logic       old_cout8;

  serial_adder_nbit #(.WIDTH(8)) u8 (
    .CLOCK_50(clk), .RESET(rst), .START(start8), .SUB(sub8), .CIN(cin8),
    .A(a8), .B(b8), .SUM(sum8), .COUT(cout8), .BUSY(busy8), .DONE(done8)
  );

  serial_adder_nbit #(.WIDTH(1)) u1 (
    .CLOCK_50(clk), .RESET(rst), .START(start1), .SUB(sub1), .CIN(cin1),
    .A(a1), .B(b1), .SUM(sum1), .COUT(cout1), .BUSY(busy1), .DONE(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation with per-cycle handshake and result checks
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic cin, input bit ignore);
    logic [8:0] full;
    logic [7:0] nsum;
    logic       ncout;
    logic [7:0] esum;
    logic       ecout;
    if (!sub) begin
      full  = 9'(a) + 9'(b) + 9'(cin);
      nsum  = full[7:0];
      ncout = full[8];
    end else begin
      nsum  = 8'(a - b);
      ncout = (a >= b);
    end
    a8 = a; b8 = b; sub8 = sub; cin8 = cin; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      start8 = ignore && (cyc == 3 || cyc == 9);
      if (start8) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      end
      esum  = (cyc == 9) ? nsum : old_sum8;
      ecout = (cyc == 9) ? ncout : old_cout8;
      total++;
      if (busy8 !== 1'b1) begin
        bad++; $display("FAIL busy8 cyc%0d: got %b want 1", cyc, busy8);
      end
      total++;
      if (done8 !== (cyc == 9)) begin
        bad++; $display("FAIL done8 cyc%0d: got %b want %b", cyc, done8, cyc == 9);
      end
      total++;
      if (sum8 !== esum || cout8 !== ecout) begin
        bad++;
        $display("FAIL result8 cyc%0d: got %b/%h want %b/%h", cyc, cout8, sum8, ecout, esum);
      end
      step();
    end
    start8 = 1'b0;
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== nsum || cout8 !== ncout) begin
      bad++;
      $display("FAIL idle8: got busy=%b done=%b %b/%h want 0 0 %b/%h",
               busy8, done8, cout8, sum8, ncout, nsum);
    end
    old_sum8  = nsum;
    old_cout8 = ncout;
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    step(); step();
    total++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      bad++; $display("FAIL reset8: got %h %b %b %b want 00 0 0 0", sum8, cout8, busy8, done8);
    end
    total++;
    if (sum1 !== 1'b0 || cout1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++; $display("FAIL reset1: got %b %b %b %b want 0 0 0 0", sum1, cout1, busy1, done1);
    end
    rst = 1'b0;
    old_sum8 = 8'h00; old_cout8 = 1'b0;
    step();
  endtask

  task automatic test_add;
    run_op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    total++;
    if (sum8 !== 8'h96 || cout8 !== 1'b0) begin
      bad++; $display("FAIL add_5a_3c: got %b/%h want 0/96", cout8, sum8);
    end
    run_op8(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    total++;
    if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
      bad++; $display("FAIL add_ff_cin: got %b/%h want 1/00", cout8, sum8);
    end
    run_op8(8'h7F, 8'h00, 1'b0, 1'b1, 1'b0);
    total++;
    if (sum8 !== 8'h80 || cout8 !== 1'b0) begin
      bad++; $display("FAIL add_7f_cin: got %b/%h want 0/80", cout8, sum8);
    end
  endtask

  task automatic test_sub;
    run_op8(8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
    total++;
    if (sum8 !== 8'hF0 || cout8 !== 1'b0) begin
      bad++; $display("FAIL sub_10_20: got %b/%h want 0/f0", cout8, sum8);
    end
    run_op8(8'h20, 8'h20, 1'b1, 1'b0, 1'b0);
    total++;
    if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
      bad++; $display("FAIL sub_20_20: got %b/%h want 1/00", cout8, sum8);
    end
  endtask

  task automatic test_ignore_start;
    run_op8(8'hC3, 8'h5E, 1'b0, 1'b1, 1'b1);
    run_op8(8'h41, 8'h9A, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    a8 = 8'hA5; b8 = 8'h17; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    total++;
    if (busy8 !== 1'b1 || sum8 !== old_sum8) begin
      bad++; $display("FAIL mid_busy: got busy=%b sum=%h want 1 %h", busy8, sum8, old_sum8);
    end
    rst = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    step();
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      bad++;
      $display("FAIL abort: got busy=%b done=%b %b/%h want 0 0 0/00", busy8, done8, cout8, sum8);
    end
    rst = 1'b0; start8 = 1'b0;
    old_sum8 = 8'h00; old_cout8 = 1'b0;
    step();
    total++;
    if (busy8 !== 1'b0) begin
      bad++; $display("FAIL start_lost: got busy=%b want 0", busy8);
    end
    run_op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // WIDTH=1 exhaustive add, back-to-back every 3 cycles
  task automatic test_width1;
    logic [1:0] full;
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i); b1 = 1'(i >> 1); cin1 = 1'(i >> 2); sub1 = 1'b0; start1 = 1'b1;
      full = 2'(a1) + 2'(b1) + 2'(cin1);
      step();
      start1 = 1'b0;
      total++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        bad++; $display("FAIL w1_cyc1 %0d: got busy=%b done=%b want 1 0", i, busy1, done1);
      end
      step();
      total++;
      if (busy1 !== 1'b1 || done1 !== 1'b1 || {cout1, sum1} !== full) begin
        bad++;
        $display("FAIL w1_done %0d: got busy=%b done=%b %b%b want 1 1 %b",
                 i, busy1, done1, cout1, sum1, full);
      end
      step();
      total++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
        bad++; $display("FAIL w1_idle %0d: got busy=%b done=%b want 0 0", i, busy1, done1);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    old_sum8 = 8'h00; old_cout8 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_nbit.md
# serial_adder_nbit

Parametrised bit-serial adder/subtractor, the sequential successor to the board-level half adder. It latches two WIDTH-bit operands on a START strobe and resolves one bit per clock through a single full-adder cell and a carry flip-flop. It presents a registered WIDTH-bit result plus carry-out with a BUSY/DONE handshake. It sits behind the DE2 switch/key front end and drives the result LEDs, and is reused wherever area matters more than latency.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 1..32.
- CLOCK_50  input  1  system clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- SUB  input  1  mode, sampled with START: 0 = add, 1 = subtract.
- CIN  input  1  carry-in for add mode, sampled with START; ignored when SUB=1.
- A  input  WIDTH  operand A, sampled with START.
- B  input  WIDTH  operand B, sampled with START.
- SUM  output  WIDTH  registered result; holds the last completed operation.
- COUT  output  1  registered carry-out; in subtract mode 1 = no borrow (A >= B).
- BUSY  output  1  high from the cycle after START is accepted until the return to IDLE.
- DONE  output  1  single-cycle pulse; SUM and COUT are valid and updated.

## Operation
- FSM states:
  - IDLE -> ADD on START.
  - ADD -> FIN after the bit WIDTH-1 step.
  - FIN -> IDLE unconditionally.
- On START accepted in IDLE, registers load as follows:
  - A shift register <= A.
  - B shift register <= SUB ? ~B : B.
  - Carry <= SUB ? 1 : CIN.
  - Bit counter <= 0.
- ADD, each cycle:
  - s = a0 ^ b0 ^ c.
  - c <= majority(a0, b0, c).
  - s shifts into the working result register from the MSB end.
  - Operand registers shift right by one.
  - Counter increments.
- The last ADD cycle (counter = WIDTH-1) writes the full result into SUM and the final carry into COUT.
- FIN asserts DONE for exactly one cycle.
- Arithmetic:
  - Add mode: {COUT,SUM} = A + B + CIN, modulo 2^(WIDTH+1).
  - Subtract mode: SUM = (A - B) mod 2^WIDTH, COUT = (A >= B) unsigned.
- START while BUSY (ADD or FIN) is ignored. It is not queued, and operands and mode are not resampled.
- START held high continuously re-triggers in each IDLE cycle.
- SUM/COUT change only on completion of an operation or on reset. They remain stable during a subsequent operation.
- WIDTH = 1: ADD lasts one cycle; the counter is at least 1 bit wide.
- Reset values: SUM = 0, COUT = 0, BUSY = 0, DONE = 0, state IDLE, internal carry/counter/shift registers 0.
- RESET asserted mid-operation aborts it. Next cycle: IDLE, all outputs at reset values, partial result discarded.
- RESET and START in the same cycle: RESET wins and START is lost.

## Timing
- Cycle 0: START = 1 sampled in IDLE.
- Cycles 1..WIDTH: state ADD, BUSY = 1.
- Cycle WIDTH+1: state FIN, BUSY = 1, DONE = 1, SUM/COUT show the new result (written at the end of cycle WIDTH).
- Cycle WIDTH+2: IDLE, BUSY = 0, DONE = 0; a START here is accepted.
- Latency START -> DONE: WIDTH+1 cycles.
- Throughput: one operation per WIDTH+2 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, SUB=0, CIN=0, A=0x5A, B=0x3C -> DONE at cycle 9, SUM=0x96, COUT=0, BUSY high cycles 1..9.
- WIDTH=8, SUB=0, CIN=1, A=0xFF, B=0x00 -> SUM=0x00, COUT=1. Then A=0x7F, B=0x00, CIN=1 -> SUM=0x80, COUT=0.
- WIDTH=8, SUB=1, A=0x10, B=0x20 -> SUM=0xF0, COUT=0. Then A=0x20, B=0x20 -> SUM=0x00, COUT=1.
- START pulses at cycles 3 and 9 with different operands during a busy operation -> ignored. Result equals the first operation only, single DONE, SUM unchanged until that DONE.
- RESET at cycle 4 of an operation -> cycle 5 shows BUSY=0, DONE=0, SUM=0, COUT=0. A fresh START afterwards completes correctly in 9 cycles.
- WIDTH=1: all 8 combinations of A/B/CIN (SUB=0) -> {COUT,SUM} = A+B+CIN, DONE at cycle 2, back-to-back START every 3 cycles.
